// File: rtl/lcd_text_driver.sv
// lcd_text_driver: renders eight 5-bit character codes as ASCII on line 1 of an
// HD44780-compatible 16x2 LCD over an 8-bit write-only bus. All LCD timing is
// counted; the busy flag is never read.
//
// Optional build macro LCD_MODE_LABEL_EN: when defined, every frame appends a
// line-2 label "TX" or "RX" chosen by the snapshotted iMode.
//
// state         | meaning
// S_PWR_WAIT    | power-on delay before the first LCD access
// S_FRAME_START | capture iChars/iMode snapshot; doubles as first SETUP cycle of 0x80
// S_SETUP       | DATA/RS driven, EN low
// S_EN_HI       | EN strobe high
// S_WAIT        | EN low, command/data execution delay
//
// ready_q selects the byte table: low = INIT commands, high = LINE1 (and label) writes.
module lcd_text_driver #(
  parameter int EN_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  parameter int PWR_WAIT_CYC = 750000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [39:0] iChars,
  input  logic        iMode,
  output logic [7:0]  oLCD_DATA,
  output logic        oLCD_RS,
  output logic        oLCD_RW,
  output logic        oLCD_EN,
  output logic        oLCD_ON,
  output logic        oLCD_BLON,
  output logic        oReady,
  output logic        oFrameDone
);

  localparam int MAX_A   = (EN_PULSE_CYC > CMD_WAIT_CYC) ? EN_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MAX_B   = (CLR_WAIT_CYC > PWR_WAIT_CYC) ? CLR_WAIT_CYC : PWR_WAIT_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] PWR_LD  = CNT_W'(PWR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD   = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD  = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD  = CNT_W'(CLR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(1);

  localparam logic [3:0] INIT_LAST = 4'd3;
`ifdef LCD_MODE_LABEL_EN
  localparam logic [3:0] FRAME_LAST = 4'd11;
`else
  localparam logic [3:0] FRAME_LAST = 4'd8;
`endif

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_FRAME_START,
    S_SETUP,
    S_EN_HI,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       step_q, step_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             frame_done_q, frame_done_d;
  logic [39:0]      snap_q, snap_d;
`ifdef LCD_MODE_LABEL_EN
  logic             mode_q, mode_d;
`else
  logic             unused_mode;
  assign unused_mode = iMode;
`endif

  logic [4:0] snap_chars [8];
  logic [3:0] nxt_step;
  logic [2:0] char_idx;
  logic [7:0] nxt_data;
  logic       nxt_rs;
  logic       last_step;

  function automatic logic [7:0] code_to_ascii(input logic [4:0] code);
    return (code < 5'd26) ? (8'h41 + {3'b000, code}) : 8'h20;
  endfunction

  // split the snapshot into per-character codes
  always_comb begin
    for (int k = 0; k < 8; k++) snap_chars[k] = snap_q[5*k +: 5];
  end

  // byte and RS for the write following the current one (column 0 = char7)
  always_comb begin
    nxt_step = step_q + 4'd1;
    char_idx = 3'(4'd8 - nxt_step);
    nxt_data = 8'h00;
    nxt_rs   = 1'b0;
    if (!ready_q) begin
      case (nxt_step)
        4'd1:    nxt_data = 8'h0C;
        4'd2:    nxt_data = 8'h01;
        4'd3:    nxt_data = 8'h06;
        default: nxt_data = 8'h38;
      endcase
    end else if (nxt_step <= 4'd8) begin
      nxt_data = code_to_ascii(snap_chars[char_idx]);
      nxt_rs   = 1'b1;
    end
`ifdef LCD_MODE_LABEL_EN
    else if (nxt_step == 4'd9) begin
      nxt_data = 8'hC0;
    end else begin
      nxt_rs   = 1'b1;
      nxt_data = (nxt_step == 4'd10) ? (mode_q ? 8'h54 : 8'h52) : 8'h58;
    end
`endif
  end

  assign last_step = ready_q ? (step_q == FRAME_LAST) : (step_q == INIT_LAST);

  // sequencer next-state: power-up wait, shared write engine, frame loop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    data_d  = data_q;
    rs_d    = rs_q;
    en_d    = en_q;
    ready_d = ready_q;
    snap_d  = snap_q;
`ifdef LCD_MODE_LABEL_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          step_d  = 4'd0;
          data_d  = 8'h38;
          rs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FRAME_START: begin
        // this cycle already drives 0x80, so only one SETUP cycle remains
        snap_d  = iChars;
`ifdef LCD_MODE_LABEL_EN
        mode_d  = iMode;
`endif
        state_d = S_SETUP;
        cnt_d   = '0;
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EN_HI;
          en_d    = 1'b1;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_EN_HI: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          en_d    = 1'b0;
          cnt_d   = (!rs_q && data_q == 8'h01) ? CLR_LD : CMD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (last_step) begin
            state_d = S_FRAME_START;
            ready_d = 1'b1;
            step_d  = 4'd0;
            data_d  = 8'h80;
            rs_d    = 1'b0;
          end else begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
            step_d  = nxt_step;
            data_d  = nxt_data;
            rs_d    = nxt_rs;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_PWR_WAIT;
        cnt_d   = PWR_LD;
      end
    endcase
    frame_done_d = ready_q && (state_d == S_WAIT) && (cnt_d == '0) && (step_d == FRAME_LAST);
  end

  // state and registered outputs; reset drops EN without waiting for a clock
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= S_PWR_WAIT;
      cnt_q        <= PWR_LD;
      step_q       <= 4'd0;
      data_q       <= 8'h00;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
      ready_q      <= 1'b0;
      frame_done_q <= 1'b0;
      snap_q       <= '0;
`ifdef LCD_MODE_LABEL_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      data_q       <= data_d;
      rs_q         <= rs_d;
      en_q         <= en_d;
      ready_q      <= ready_d;
      frame_done_q <= frame_done_d;
      snap_q       <= snap_d;
`ifdef LCD_MODE_LABEL_EN
      mode_q       <= mode_d;
`endif
    end
  end

  assign oLCD_DATA  = data_q;
  assign oLCD_RS    = rs_q;
  assign oLCD_RW    = 1'b0;
  assign oLCD_EN    = en_q;
  assign oLCD_ON    = 1'b1;
  assign oLCD_BLON  = 1'b1;
  assign oReady     = ready_q;
  assign oFrameDone = frame_done_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver with reduced timing parameters.
module tb_lcd_text_driver;

  localparam int EN_P = 2;
  localparam int CMD_W = 4;
  localparam int CLR_W = 8;
  localparam int PWR_W = 10;
`ifdef LCD_MODE_LABEL_EN
  localparam int FRAME_CYC = 96;
`else
  localparam int FRAME_CYC = 72;
`endif

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [39:0] iChars = '0;
  logic        iMode = 1'b0;
  logic [7:0]  oLCD_DATA;
  logic        oLCD_RS, oLCD_RW, oLCD_EN, oLCD_ON, oLCD_BLON, oReady, oFrameDone;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int fd_cyc[$];

  lcd_text_driver #(
    .EN_PULSE_CYC(EN_P),
    .CMD_WAIT_CYC(CMD_W),
    .CLR_WAIT_CYC(CLR_W),
    .PWR_WAIT_CYC(PWR_W)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iChars(iChars),
    .iMode(iMode),
    .oLCD_DATA(oLCD_DATA),
    .oLCD_RS(oLCD_RS),
    .oLCD_RW(oLCD_RW),
    .oLCD_EN(oLCD_EN),
    .oLCD_ON(oLCD_ON),
    .oLCD_BLON(oLCD_BLON),
    .oReady(oReady),
    .oFrameDone(oFrameDone)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  always @(negedge iCLK) if (!iRST && oFrameDone) fd_cyc.push_back(cyc);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_write(output logic [7:0] d, output logic r, output int c);
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = oLCD_EN;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge iCLK);
      if (oLCD_EN && !prev) found = 1'b1;
      prev = oLCD_EN;
    end
    check_eq("en_rise_seen", 32'(found), 32'd1);
    d = oLCD_DATA;
    r = oLCD_RS;
    c = cyc;
  endtask

  task automatic run_init(input string tag, input int rel, output int e06);
    logic [7:0] d;
    logic       r;
    int         c, pc;
    wait_write(d, r, c);
    check_eq({tag, "_38_delay"}, 32'(c - rel), 32'd12);
    check_eq({tag, "_38"}, {23'b0, r, d}, 32'h038);
    pc = c;
    wait_write(d, r, c);
    check_eq({tag, "_0c_gap"}, 32'(c - pc), 32'd8);
    check_eq({tag, "_0c"}, {23'b0, r, d}, 32'h00C);
    pc = c;
    wait_write(d, r, c);
    check_eq({tag, "_01_gap"}, 32'(c - pc), 32'd8);
    check_eq({tag, "_01"}, {23'b0, r, d}, 32'h001);
    pc = c;
    wait_write(d, r, c);
    check_eq({tag, "_06_gap"}, 32'(c - pc), 32'd12);
    check_eq({tag, "_06"}, {23'b0, r, d}, 32'h006);
    check_eq({tag, "_ready_at_06"}, 32'(oReady), 32'd0);
    e06 = c;
    repeat (5) @(negedge iCLK);
    check_eq({tag, "_ready_late_wait"}, 32'(oReady), 32'd0);
    @(negedge iCLK);
    check_eq({tag, "_ready_after_wait"}, 32'(oReady), 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] exp_data [8], input logic exp_mode,
                           input int change_at, input logic [39:0] new_chars, input logic new_mode);
    logic [7:0] d;
    logic       r;
    int         c;
    wait_write(d, r, c);
    check_eq({tag, "_cmd80"}, {23'b0, r, d}, 32'h080);
    for (int k = 0; k < 8; k++) begin
      wait_write(d, r, c);
      check_eq($sformatf("%s_col%0d", tag, k), {23'b0, r, d}, {23'b0, 1'b1, exp_data[k]});
      if (k == change_at) begin
        iChars = new_chars;
        iMode  = new_mode;
      end
    end
`ifdef LCD_MODE_LABEL_EN
    wait_write(d, r, c);
    check_eq({tag, "_cmdC0"}, {23'b0, r, d}, 32'h0C0);
    wait_write(d, r, c);
    check_eq({tag, "_label0"}, {23'b0, r, d}, exp_mode ? 32'h154 : 32'h152);
    wait_write(d, r, c);
    check_eq({tag, "_label1"}, {23'b0, r, d}, 32'h158);
`else
    if (exp_mode) check_eq({tag, "_mode_ignored"}, 32'(oLCD_EN), 32'd1);
`endif
  endtask

  initial begin
    logic [7:0] exp_a [8];
    logic [7:0] exp_b [8];
    logic [7:0] exp_p [8];
    logic [39:0] pat;
    logic [7:0] d;
    logic       r;
    int         c, rel, e06;

    exp_a = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
    exp_b = '{8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42, 8'h42};
    exp_p = '{8'h5A, 8'h20, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h20};
    pat   = {5'd25, 5'd26, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd31};

    repeat (3) @(negedge iCLK);
    check_eq("rst_data", 32'(oLCD_DATA), 32'h00);
    check_eq("rst_rs", 32'(oLCD_RS), 32'd0);
    check_eq("rst_en", 32'(oLCD_EN), 32'd0);
    check_eq("rst_ready", 32'(oReady), 32'd0);
    check_eq("rst_frame_done", 32'(oFrameDone), 32'd0);
    check_eq("rw_low", 32'(oLCD_RW), 32'd0);
    check_eq("on_high", 32'({oLCD_ON, oLCD_BLON}), 32'd3);

    iRST = 1'b0;
    rel  = cyc;
    run_init("init", rel, e06);

    run_frame("frA", exp_a, 1'b0, -1, '0, 1'b0);
    run_frame("frB", exp_a, 1'b0, 2, {8{5'd1}}, 1'b1);
    run_frame("frC", exp_b, 1'b1, 0, pat, 1'b1);
    run_frame("frD", exp_p, 1'b1, -1, pat, 1'b1);

    wait_write(d, r, c);
    check_eq("frE_cmd80", {23'b0, r, d}, 32'h080);
    check_eq("fd_count", 32'(fd_cyc.size()), 32'd4);
    if (fd_cyc.size() >= 4) begin
      check_eq("fd_first", 32'(fd_cyc[0] - e06), 32'(5 + FRAME_CYC));
      for (int i = 1; i < 4; i++)
        check_eq($sformatf("fd_period%0d", i), 32'(fd_cyc[i] - fd_cyc[i-1]), 32'(FRAME_CYC));
    end

    wait_write(d, r, c);
    check_eq("frE_col0_en", 32'(oLCD_EN), 32'd1);
    iRST = 1'b1;
    #1;
    check_eq("async_rst_en", 32'(oLCD_EN), 32'd0);
    check_eq("async_rst_ready", 32'(oReady), 32'd0);
    check_eq("async_rst_data", 32'(oLCD_DATA), 32'h00);
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    rel  = cyc;
    run_init("reinit", rel, e06);
    wait_write(d, r, c);
    check_eq("reinit_cmd80", {23'b0, r, d}, 32'h080);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
